spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//   SPI mode-0 master that drives the peripheral-side SPI bridge. Each transfer is one
//   16-bit frame: a command byte {rw, addr[6:0]} followed by one data byte.
//   A host-side start/done handshake launches a frame. The block generates sclk, cs_n and
//   mosi from the system clock and captures read data from miso.
//   Used by test harnesses and on-chip controllers to program the PWM register file.
// PARAMETERS
//   CLK_DIV       4   clk cycles per sclk half-period; legal range >= 1
//   RD_LSB_FIRST  1   1: first miso data bit -> rdata[0]; 0: first miso data bit -> rdata[7]
// PORTS
//   clk     in   1  system clock; all logic on posedge
//   rst_n   in   1  asynchronous, active-low reset
//   start   in   1  launch request; sampled only in IDLE
//   rw      in   1  1 = write frame, 0 = read frame; latched on start
//   addr    in   7  register address; latched on start
//   wdata   in   8  write data; latched on start; ignored for reads
//   busy    out  1  high from the cycle after start is accepted until done
//   done    out  1  one-cycle pulse at end of frame
//   rdata   out  8  last read byte; held until the next read frame completes
//   sclk    out  1  SPI clock; idles low
//   cs_n    out  1  SPI chip select, active low; idles high
//   mosi    out  1  SPI data to peripheral, MSB first
//   miso    in   1  SPI data from peripheral
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0,
//     rdata=8'h00, counters=0. A frame in flight is abandoned and produces no done pulse.
//   Frame shift register: tx = {rw, addr, (rw ? wdata : 8'h00)}, 16 bits, sent MSB first.
//   States: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> IDLE.
//   IDLE: start=1 at cycle 0 latches tx. At cycle 1: cs_n=0, busy=1, mosi=tx[15], go SETUP.
//     start=0: remain in IDLE.
//   SETUP: hold for CLK_DIV cycles with sclk=0, then go SHIFT_HI.
//   SHIFT_HI: sclk=1 (rising edge on entry); hold CLK_DIV cycles.
//     miso is sampled in the entry cycle only when rw=0 and bit_cnt is 8..15.
//     Sampled bits shift into rd_sh; the shift direction is set by RD_LSB_FIRST.
//     Exit to SHIFT_LO.
//   SHIFT_LO: sclk=0 (falling edge on entry).
//     If bit_cnt<15: mosi <= next tx bit and bit_cnt++.
//     If bit_cnt==15: mosi <= 0 and the low phase serves as hold time.
//     Hold CLK_DIV cycles. Then, if the frame is finished: cs_n=1, busy=0, done=1 for one
//     cycle, rdata <= rd_sh (read frames only), go IDLE. Otherwise go SHIFT_HI.
//   Timing: cs_n is low for exactly 33*CLK_DIV cycles (cycles 1..33*CLK_DIV).
//     done and cs_n=1 occur in cycle 33*CLK_DIV+1. sclk has exactly 16 rising edges per frame.
//   mosi changes only while sclk=0, or in the cs_n-falling cycle. It is stable through each
//     high phase.
//   start while busy=1 is ignored (not queued). The earliest next start is accepted in the
//     cycle done is high, so back-to-back frames have cs_n high for >= 1 cycle.
//   rw, addr and wdata may change freely after the start cycle; the latched values are used.
//   Write frames never modify rdata.
//   Counters: div_cnt is $clog2(CLK_DIV+1) bits and wraps to 0 at CLK_DIV-1.
//     bit_cnt is 4 bits and saturates at 15; there is no wrap within a frame.
// TESTING
//   1. CLK_DIV=4; write rw=1 addr=7'h05 wdata=8'hA5 -> mosi frame 16'h85A5; 16 sclk rises;
//      cs_n low 132 cycles; done at cycle 133; rdata unchanged (8'h00).
//   2. CLK_DIV=4; read addr=7'h02; slave model drives 8'h3C LSB first on miso ->
//      mosi frame 16'h0200; rdata=8'h3C at done.
//   3. start held high for 3 cycles, then pulsed again mid-frame -> exactly one frame;
//      only one done pulse.
//   4. start asserted in the done cycle -> second frame starts; cs_n high exactly 1 cycle
//      between frames.
//   5. rst_n low at cycle 60 of a read frame -> cs_n=1 and sclk=0 immediately; no done;
//      rdata=8'h00; next frame completes normally.
//   6. CLK_DIV=1; write 8'hFF to 7'h7F -> cs_n low 33 cycles; sclk toggles every cycle;
//      mosi frame 16'hFFFF.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one 16-bit frame {rw, addr[6:0], data[7:0]} per start pulse,
// sclk derived from clk by CLK_DIV, read byte captured from miso on sclk rising edges.
module spi_master_ctrl #(
  parameter int CLK_DIV      = 4,
  parameter bit RD_LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HI    = 2'd2;
  localparam logic [1:0] S_LO    = 2'd3;

  logic [1:0]    r_state;
  logic [DW-1:0] r_div_cnt;
  logic [3:0]    r_bit_cnt;
  logic          r_last;
  logic          r_sclk;
  logic          r_cs_n;
  logic          r_mosi;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_rdata;
  logic [7:0]    r_rd_sh;
  logic [14:0]   r_tx;
  logic          r_rw;

  logic [15:0]   w_frame;
  logic          w_div_end;
  logic          w_accept;
  logic          w_adv_bit;
  logic          w_sample;

  assign w_frame   = {rw, addr, rw ? wdata : 8'h00};
  assign w_div_end = (r_div_cnt == DIV_LAST);
  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_adv_bit = (r_state == S_HI) && w_div_end && (r_bit_cnt != 4'd15);
  // Data bits sit in bit slots 8..15; miso is taken on the first cycle of each high phase.
  assign w_sample  = (r_state == S_HI) && (r_div_cnt == '0) && !r_rw && r_bit_cnt[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= 4'd0;
      r_last    <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_SETUP;
            r_cs_n    <= 1'b0;
            r_busy    <= 1'b1;
            r_mosi    <= w_frame[15];
            r_div_cnt <= '0;
            r_bit_cnt <= 4'd0;
            r_last    <= 1'b0;
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_state   <= S_HI;
            r_sclk    <= 1'b1;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        S_HI: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_state   <= S_LO;
            r_sclk    <= 1'b0;
            if (r_bit_cnt != 4'd15) begin
              r_mosi    <= r_tx[14];
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
              r_mosi <= 1'b0;
              r_last <= 1'b1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        S_LO: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            if (r_last) begin
              r_state <= S_IDLE;
              r_cs_n  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              if (!r_rw) r_rdata <= r_rd_sh;
            end else begin
              r_state <= S_HI;
              r_sclk  <= 1'b1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Frame payload and read shifter carry no reset: both are fully loaded before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tx <= w_frame[14:0];
      r_rw <= rw;
    end else if (w_adv_bit) begin
      r_tx <= {r_tx[13:0], 1'b0};
    end
    if (w_sample) begin
      r_rd_sh <= RD_LSB_FIRST ? {miso, r_rd_sh[7:1]} : {r_rd_sh[6:0], miso};
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign sclk  = r_sclk;
  assign cs_n  = r_cs_n;
  assign mosi  = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV=4 LSB-first, CLK_DIV=1 MSB-first),
// a frame-timing reference model, a slave/monitor, directed and random frames.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st[2], rwv[2], misov[2];
  logic [6:0] ad[2];
  logic [7:0] wd[2], sb[2];
  logic       bsy[2], dn[2], sck[2], csn[2], mo[2];
  logic [7:0] rd[2];

  int DIVS [2] = '{4, 1};
  int n_tests = 0;
  int n_fail  = 0;

  spi_master_ctrl #(.CLK_DIV(4), .RD_LSB_FIRST(1'b1)) u_div4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .rw(rwv[0]), .addr(ad[0]), .wdata(wd[0]),
    .busy(bsy[0]), .done(dn[0]), .rdata(rd[0]), .sclk(sck[0]), .cs_n(csn[0]),
    .mosi(mo[0]), .miso(misov[0]));

  spi_master_ctrl #(.CLK_DIV(1), .RD_LSB_FIRST(1'b0)) u_div1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .rw(rwv[1]), .addr(ad[1]), .wdata(wd[1]),
    .busy(bsy[1]), .done(dn[1]), .rdata(rd[1]), .sclk(sck[1]), .cs_n(csn[1]),
    .mosi(mo[1]), .miso(misov[1]));

  task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", nm, i, act, exp, $time);
    end
  endtask

  // Reference model: frame position k counts cycles since the accepting edge.
  bit          m_act[2], m_done[2], m_rd[2];
  int          m_k[2];
  logic [15:0] m_tx[2];
  logic [7:0]  m_sb[2], m_rdata[2];

  initial begin
    int D, h, b;
    logic es, em, ec, eb, ed;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_done[i] = 0; m_rd[i] = 0; m_k[i] = 0; m_tx[i] = '0;
      m_sb[i] = '0; m_rdata[i] = 8'h00;
    end
    forever begin
      @(posedge clk);
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          D = DIVS[i];
          if (m_act[i]) begin
            if (m_k[i] == 33 * D) begin
              m_act[i] = 0; m_done[i] = 1;
              if (m_rd[i]) m_rdata[i] = m_sb[i];
            end else begin
              m_k[i]++;
            end
          end else begin
            m_done[i] = 0;
            if (st[i]) begin
              m_act[i] = 1; m_k[i] = 1;
              m_tx[i]  = {rwv[i], ad[i], rwv[i] ? wd[i] : 8'h00};
              m_rd[i]  = !rwv[i];
              m_sb[i]  = sb[i];
            end
          end
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        D = DIVS[i];
        if (!rst_n) begin
          m_act[i] = 0; m_done[i] = 0; m_rdata[i] = 8'h00;
        end
        es = 0; em = 0; ec = 1; eb = 0; ed = m_done[i];
        if (m_act[i]) begin
          ec = 0; eb = 1; ed = 0;
          if (m_k[i] > D) begin
            h  = (m_k[i] - D - 1) / D;
            es = (h % 2 == 0);
            b  = (h + 1) / 2;
            em = (b < 16) ? m_tx[i][15-b] : 1'b0;
          end else begin
            em = m_tx[i][15];
          end
        end
        chk("cs_n",  i, 16'(csn[i]), 16'(ec));
        chk("sclk",  i, 16'(sck[i]), 16'(es));
        chk("mosi",  i, 16'(mo[i]),  16'(em));
        chk("busy",  i, 16'(bsy[i]), 16'(eb));
        chk("done",  i, 16'(dn[i]),  16'(ed));
        chk("rdata", i, 16'(rd[i]),  16'(m_rdata[i]));
      end
    end
  end

  // Slave (drives miso, changes only while sclk low) and frame statistics.
  int          mon_low[2], mon_rises[2], mon_hi[2], f_low[2], f_rises[2], gap[2], dcnt[2];
  logic [15:0] mon_fr[2], f_frame[2];
  logic        p_cs[2], p_sck[2];

  initial begin
    int bi;
    for (int i = 0; i < 2; i++) begin
      misov[i] = 0; p_cs[i] = 1; p_sck[i] = 0; mon_low[i] = 0; mon_rises[i] = 0;
      mon_hi[i] = 0; f_low[i] = 0; f_rises[i] = 0; gap[i] = 0; dcnt[i] = 0;
      mon_fr[i] = '0; f_frame[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!csn[i]) begin
          if (p_cs[i]) begin
            mon_low[i] = 0; mon_rises[i] = 0; mon_fr[i] = '0; gap[i] = mon_hi[i];
          end
          mon_low[i]++;
          if (sck[i] && !p_sck[i]) begin
            mon_rises[i]++;
            mon_fr[i] = {mon_fr[i][14:0], mo[i]};
          end
          bi = sck[i] ? mon_rises[i] - 1 : mon_rises[i];
          if (bi >= 8 && bi <= 15) misov[i] = (i == 0) ? sb[i][bi-8] : sb[i][15-bi];
          else misov[i] = 1'b0;
        end else begin
          if (!p_cs[i]) begin
            f_low[i] = mon_low[i]; f_rises[i] = mon_rises[i]; f_frame[i] = mon_fr[i];
            mon_hi[i] = 0;
          end
          mon_hi[i]++;
          misov[i] = 1'b0;
        end
        if (dn[i]) dcnt[i]++;
        p_cs[i]  = csn[i];
        p_sck[i] = sck[i];
      end
    end
  end

  task automatic launch(input int i, input logic r, input logic [6:0] a, input logic [7:0] w,
                        input logic [7:0] s);
    rwv[i] = r; ad[i] = a; wd[i] = w; sb[i] = s; st[i] = 1'b1;
    @(posedge clk);
    #1;
    st[i] = 1'b0;
    rwv[i] = 1'($urandom); ad[i] = 7'($urandom); wd[i] = 8'($urandom);
  endtask

  task automatic wait_done(input int i, input int limit, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (dn[i]) break;
      if (n >= limit) begin n = -1; break; end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, g, di;
    logic r;
    logic [7:0] s;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st[i] = 0; rwv[i] = 0; ad[i] = '0; wd[i] = '0; sb[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs_n", i, 16'(csn[i]), 16'd1);
      chk("rst_sclk", i, 16'(sck[i]), 16'd0);
      chk("rst_busy", i, 16'(bsy[i]), 16'd0);
      chk("rst_rdata", i, 16'(rd[i]), 16'h00);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Write 0xA5 to 0x05
    launch(0, 1'b1, 7'h05, 8'hA5, 8'h00);
    wait_done(0, 300, n); #2;
    chk("t1_done_cycle", 0, 16'(n), 16'd133);
    chk("t1_cs_low", 0, 16'(f_low[0]), 16'd132);
    chk("t1_rises", 0, 16'(f_rises[0]), 16'd16);
    chk("t1_frame", 0, f_frame[0], 16'h85A5);
    chk("t1_rdata", 0, 16'(rd[0]), 16'h00);

    // Read from 0x02, slave returns 0x3C
    @(posedge clk); #1;
    launch(0, 1'b0, 7'h02, 8'hEE, 8'h3C);
    wait_done(0, 300, n);
    chk("t2_rdata", 0, 16'(rd[0]), 16'h3C);
    #2;
    chk("t2_frame", 0, f_frame[0], 16'h0200);

    // Held start plus a mid-frame pulse yields one frame
    @(posedge clk); #1;
    d0 = dcnt[0];
    rwv[0] = 1'b1; ad[0] = 7'h11; wd[0] = 8'h22; st[0] = 1'b1;
    repeat (3) @(posedge clk); #1; st[0] = 1'b0;
    repeat (40) @(posedge clk); #1; st[0] = 1'b1;
    @(posedge clk); #1; st[0] = 1'b0;
    wait_done(0, 300, n);
    chk("t3_finished", 0, 16'(n > 0), 16'd1);
    repeat (150) @(posedge clk); #1;
    chk("t3_one_done", 0, 16'(dcnt[0] - d0), 16'd1);

    // Start in the done cycle: back-to-back frames
    launch(0, 1'b1, 7'h33, 8'h5A, 8'h00);
    wait_done(0, 300, n); #1;
    launch(0, 1'b0, 7'h44, 8'h00, 8'h81);
    wait_done(0, 300, n);
    chk("t4_second_done", 0, 16'(n), 16'd133);
    chk("t4_rdata", 0, 16'(rd[0]), 16'h81);
    #2;
    chk("t4_gap", 0, 16'(gap[0]), 16'd1);

    // Reset in the middle of a read frame
    @(posedge clk); #1;
    launch(0, 1'b0, 7'h0A, 8'h00, 8'h5A);
    repeat (59) @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("t5_cs_n", 0, 16'(csn[0]), 16'd1);
    chk("t5_sclk", 0, 16'(sck[0]), 16'd0);
    chk("t5_rdata", 0, 16'(rd[0]), 16'h00);
    d0 = dcnt[0];
    repeat (3) @(posedge clk); #1; rst_n = 1'b1;
    repeat (150) @(posedge clk); #1;
    chk("t5_no_done", 0, 16'(dcnt[0] - d0), 16'd0);
    launch(0, 1'b0, 7'h0A, 8'h00, 8'hC3);
    wait_done(0, 300, n);
    chk("t5_next_done", 0, 16'(n), 16'd133);
    chk("t5_next_rdata", 0, 16'(rd[0]), 16'hC3);

    // CLK_DIV=1: write 0xFF to 0x7F, then an MSB-first read
    @(posedge clk); #1;
    launch(1, 1'b1, 7'h7F, 8'hFF, 8'h00);
    wait_done(1, 100, n); #2;
    chk("t6_done_cycle", 1, 16'(n), 16'd34);
    chk("t6_cs_low", 1, 16'(f_low[1]), 16'd33);
    chk("t6_rises", 1, 16'(f_rises[1]), 16'd16);
    chk("t6_frame", 1, f_frame[1], 16'hFFFF);
    @(posedge clk); #1;
    launch(1, 1'b0, 7'h15, 8'h00, 8'h96);
    wait_done(1, 100, n);
    chk("t6_rdata", 1, 16'(rd[1]), 16'h96);

    // Random frames with random gaps (gap 0 = start in the done cycle)
    for (int it = 0; it < 24; it++) begin
      di = it % 2;
      g  = $urandom_range(0, 4);
      if (g != 0) repeat (g) @(posedge clk);
      #1;
      r = 1'($urandom);
      s = 8'($urandom);
      launch(di, r, 7'($urandom), 8'($urandom), s);
      wait_done(di, 300, n);
      chk("rand_done_cycle", di, 16'(n), 16'(33 * DIVS[di] + 1));
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
